match_scheduler: RTL and testbench

MATCH_SCHEDULER -- requirements
Module: match_scheduler

---
 rtl/match_scheduler_pkg.sv | 21 ++
 rtl/match_scheduler_rr_arbiter.sv | 33 +++
 rtl/match_scheduler.sv | 161 ++++++++++++++++
 tb/tb_match_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/match_scheduler_pkg.sv
// Shared types and constants for the match scheduler and its arbiter.
package match_scheduler_pkg;

   // Job sequencing states; exactly one job is in flight at a time.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESP,
      S_CLEAR
   } sched_state;

   // Default number of cycles a job may wait for the matcher.
   localparam int unsigned DEFAULT_TIMEOUT = 64;

   // Width of a requester index; at least one bit even for a single requester.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/match_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 (wrapping) for the first active request.
module rr_arbiter
   import match_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id
);

   logic [ID_W-1:0] idx;
   logic            found;

   // Rotating priority search; the offset runs 1..NUM_REQ so last_grant itself is checked last.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      idx      = '0;
      found    = 1'b0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         idx = ID_W'((32'(last_grant) + off) % NUM_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

endmodule

// File: rtl/match_scheduler.sv
// Match scheduler: shares one string matcher among NUM_REQ requesters, one job at a time,
// with round-robin grants, a completion timeout and a valid/ready result port.
module match_scheduler
   import match_scheduler_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned ADDR_WIDTH = 4,
   parameter  int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
   localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
   input  logic                                clk,
   input  logic                                rst,
   // requester side
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_input_addr,
   output logic [NUM_REQ-1:0]                  req_ready,
   // vocabulary window configuration
   input  logic                                cfg_we,
   input  logic [ADDR_WIDTH-1:0]               cfg_vocab_start,
   input  logic [ADDR_WIDTH-1:0]               cfg_vocab_end,
   // matcher side
   output logic                                m_start,
   output logic                                m_clr,
   output logic [ADDR_WIDTH-1:0]               m_vocab_start,
   output logic [ADDR_WIDTH-1:0]               m_vocab_end,
   output logic [ADDR_WIDTH-1:0]               m_input_start,
   input  logic                                m_done,
   input  logic                                m_found,
   input  logic [ADDR_WIDTH-1:0]               m_addr_v,
   // result side
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [ID_W-1:0]                     rsp_id,
   output logic                                rsp_found,
   output logic                                rsp_timeout,
   output logic [ADDR_WIDTH-1:0]               rsp_addr,
   output logic                                busy
);

   localparam int unsigned     CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   sched_state              state;
   sched_state              state_next;
   logic [ID_W-1:0]         last_grant;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_W-1:0]         grant_id;
   logic [ID_W-1:0]         job_id;
   logic [ADDR_WIDTH-1:0]   job_addr;
   logic [ADDR_WIDTH-1:0]   win_start;
   logic [ADDR_WIDTH-1:0]   win_end;
   logic [CNT_W-1:0]        cnt;
   logic                    any_req;
   logic                    expired;

   assign any_req = |req_valid;
   assign expired = (cnt == CNT_LAST);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req        (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_id   (grant_id)
   );

   // Matcher configuration comes straight from the held window and job registers.
   assign m_vocab_start = win_start;
   assign m_vocab_end   = win_end;
   assign m_input_start = job_addr;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state decode and per-state control outputs.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      m_start    = 1'b0;
      m_clr      = 1'b0;
      rsp_valid  = 1'b0;
      busy       = 1'b1;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (any_req) begin
               req_ready  = grant;
               state_next = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            m_start    = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (m_done || expired) state_next = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = S_CLEAR;
         end
         S_CLEAR: begin
            m_clr      = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: window config, job capture, timeout counter and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant  <= ID_W'(NUM_REQ - 1);
         job_id      <= '0;
         job_addr    <= '0;
         win_start   <= '0;
         win_end     <= '0;
         cnt         <= '0;
         rsp_id      <= '0;
         rsp_found   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_addr    <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (cfg_we) begin
                  win_start <= cfg_vocab_start;
                  win_end   <= cfg_vocab_end;
               end
               if (any_req) begin
                  last_grant <= grant_id;
                  job_id     <= grant_id;
                  job_addr   <= req_input_addr[grant_id];
               end
            end
            S_LAUNCH: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               // m_done takes priority over an expiry in the same cycle
               if (m_done) begin
                  rsp_id      <= job_id;
                  rsp_found   <= m_found;
                  rsp_addr    <= m_addr_v;
                  rsp_timeout <= 1'b0;
               end else if (expired) begin
                  rsp_id      <= job_id;
                  rsp_found   <= 1'b0;
                  rsp_addr    <= '0;
                  rsp_timeout <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed self-checking bench for match_scheduler; the bench plays the matcher.
module tb_match_scheduler;

   localparam int NR = 4;
   localparam int AW = 4;
   localparam int TO = 64;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NR-1:0]         req_valid;
   logic [NR-1:0][AW-1:0] req_input_addr;
   logic [NR-1:0]         req_ready;
   logic                  cfg_we;
   logic [AW-1:0]         cfg_vocab_start, cfg_vocab_end;
   logic                  m_start, m_clr;
   logic [AW-1:0]         m_vocab_start, m_vocab_end, m_input_start;
   logic                  m_done, m_found;
   logic [AW-1:0]         m_addr_v;
   logic                  rsp_valid, rsp_ready;
   logic [1:0]            rsp_id;
   logic                  rsp_found, rsp_timeout;
   logic [AW-1:0]         rsp_addr;
   logic                  busy;

   logic [27:0] all_out;
   assign all_out = {req_ready, m_start, m_clr, m_vocab_start, m_vocab_end, m_input_start,
                     rsp_valid, rsp_id, rsp_found, rsp_timeout, rsp_addr, busy};

   int tests = 0;
   int fails = 0;
   logic [AW-1:0] win_s = '0;
   logic [AW-1:0] win_e = '0;

   always #5 clk = ~clk;

   match_scheduler #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_input_addr(req_input_addr), .req_ready(req_ready),
      .cfg_we(cfg_we), .cfg_vocab_start(cfg_vocab_start), .cfg_vocab_end(cfg_vocab_end),
      .m_start(m_start), .m_clr(m_clr),
      .m_vocab_start(m_vocab_start), .m_vocab_end(m_vocab_end), .m_input_start(m_input_start),
      .m_done(m_done), .m_found(m_found), .m_addr_v(m_addr_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_found(rsp_found), .rsp_timeout(rsp_timeout), .rsp_addr(rsp_addr),
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One complete job from grant to return-to-idle.
   // done_after < 0 means the matcher never answers.
   task automatic do_job(input logic [3:0] reqs, input int exp_id, input logic [3:0] in_addr,
                         input int done_after, input logic found, input logic [3:0] av,
                         input int hold, input logic cfg_idle, input logic cfg_wait,
                         input logic [3:0] cs, input logic [3:0] ce);
      int cyc;
      int exp_cyc;
      logic [9:0] exp_rsp;
      for (int i = 0; i < NR; i++) req_input_addr[i] = ~in_addr;
      req_input_addr[exp_id] = in_addr;
      req_valid = reqs;
      if (cfg_idle) begin
         cfg_we = 1'b1; cfg_vocab_start = cs; cfg_vocab_end = ce;
         win_s = cs; win_e = ce;
      end
      #1;
      check("grant", 32'(req_ready), 32'(1 << exp_id));
      check("idle_busy", 32'(busy), 0);
      tick();
      cfg_we = 1'b0;
      check("launch_start", 32'(m_start), 1);
      check("launch_ready", 32'(req_ready), 0);
      check("launch_cfg", {20'h0, m_input_start, m_vocab_start, m_vocab_end}, {20'h0, in_addr, win_s, win_e});
      tick();
      check("wait_start", 32'(m_start), 0);
      if (cfg_wait) begin
         cfg_we = 1'b1; cfg_vocab_start = cs; cfg_vocab_end = ce;
      end
      cyc = 0;
      while (rsp_valid !== 1'b1 && cyc < 200) begin
         if (cyc == done_after) begin
            m_done = 1'b1; m_found = found; m_addr_v = av;
         end
         tick();
         cfg_we = 1'b0; m_done = 1'b0; m_found = 1'b0; m_addr_v = '0;
         cyc++;
      end
      exp_cyc = (done_after < 0) ? TO : done_after + 1;
      check("rsp_latency", 32'(cyc), 32'(exp_cyc));
      exp_rsp = (done_after < 0) ? {2'(exp_id), 1'b0, 1'b1, 4'h0, 2'b00}
                                 : {2'(exp_id), found, 1'b0, av, 2'b00};
      check("rsp_fields", {22'h0, rsp_id, rsp_found, rsp_timeout, rsp_addr, 2'b00}, {22'h0, exp_rsp});
      for (int h = 0; h < hold; h++) begin
         tick();
         check("hold_rsp", {21'h0, rsp_valid, rsp_id, rsp_found, rsp_timeout, rsp_addr, 2'b00},
               {21'h0, 1'b1, exp_rsp});
         check("hold_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("clear", {29'h0, m_clr, rsp_valid, busy}, {29'h0, 1'b1, 1'b0, 1'b1});
      check("clear_cfg", {20'h0, m_input_start, m_vocab_start, m_vocab_end}, {20'h0, in_addr, win_s, win_e});
      tick();
      check("back_idle", {30'h0, m_clr, busy}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_input_addr = '0; cfg_we = 1'b0;
      cfg_vocab_start = '0; cfg_vocab_end = '0; m_done = 1'b0; m_found = 1'b0;
      m_addr_v = '0; rsp_ready = 1'b0;
      repeat (3) tick();
      check("reset_outputs", 32'(all_out), 0);
      rst = 1'b0;
      tick();
      check("post_reset_idle", 32'(all_out), 0);

      // continuous requests: 0,1,2,3,0; window written together with the first grant
      do_job(4'hF, 0, 4'h1, 0, 1'b1, 4'h9, 0, 1'b1, 1'b0, 4'h2, 4'hA);
      do_job(4'hF, 1, 4'h2, 1, 1'b0, 4'h3, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      do_job(4'hF, 2, 4'h4, 2, 1'b1, 4'h6, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      do_job(4'hF, 3, 4'h8, 3, 1'b1, 4'hB, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      do_job(4'hF, 0, 4'hC, 0, 1'b0, 4'h7, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      req_valid = '0;

      // m_done while idle must be ignored
      m_done = 1'b1; m_found = 1'b1; m_addr_v = 4'h5;
      tick();
      m_done = 1'b0; m_found = 1'b0; m_addr_v = '0;
      check("idle_done_ignored", {30'h0, busy, rsp_valid}, 0);
      check("idle_no_ready", 32'(req_ready), 0);

      // single request from requester 0
      do_job(4'h1, 0, 4'h3, 0, 1'b1, 4'h5, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      req_valid = '0;
      // backpressure for 10 cycles
      do_job(4'h4, 2, 4'h6, 2, 1'b1, 4'hC, 10, 1'b0, 1'b0, 4'h0, 4'h0);
      req_valid = '0;
      // config write during WAIT is ignored
      do_job(4'h8, 3, 4'h7, 1, 1'b1, 4'h1, 0, 1'b0, 1'b1, 4'h7, 4'hF);
      req_valid = '0;
      do_job(4'h2, 1, 4'h5, 0, 1'b0, 4'h2, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      // config write in IDLE with a grant takes effect for that job
      do_job(4'h2, 1, 4'h9, 0, 1'b1, 4'h4, 0, 1'b1, 1'b0, 4'h7, 4'hF);
      req_valid = '0;
      // matcher never answers
      do_job(4'h1, 0, 4'h4, -1, 1'b1, 4'hE, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      req_valid = '0;

      // reset in the middle of WAIT
      req_valid = 4'h4;
      tick();
      req_valid = '0;
      tick();
      tick();
      check("mid_job_busy", 32'(busy), 1);
      rst = 1'b1;
      tick();
      check("mid_reset_outputs", 32'(all_out), 0);
      rst = 1'b0;
      win_s = '0; win_e = '0;
      tick();
      check("after_reset_quiet", {30'h0, rsp_valid, m_clr}, 0);
      do_job(4'hF, 0, 4'hA, 1, 1'b1, 4'h3, 0, 1'b0, 1'b0, 4'h0, 4'h0);
      req_valid = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
